// File: rtl/instruction_issue_unit.sv
// Instruction issue front end: loadable program store, PC stepping, valid/ready issue and PC-relative redirects.
// Optional ISSUE_ILLEGAL_OPCODE_EN replaces opcodes above 5'b10110 with NOP and adds illegal_seen.
module instruction_issue_unit #(
  parameter int DEPTH  = 32,
  parameter int ADDR_W = 5,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_we,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [31:0]       load_data,
  input  logic              start,
  output logic              instr_valid,
  input  logic              instr_ready,
  output logic [31:0]       instr_out,
  output logic [ADDR_W-1:0] instr_pc,
  input  logic              redirect_valid,
  input  logic [26:0]       redirect_offset,
  output logic              busy,
`ifdef ISSUE_ILLEGAL_OPCODE_EN
  output logic              illegal_seen,
`endif
  output logic              halted,
  output logic [CNT_W-1:0]  issued_count
);

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_ISSUE, S_HALT} state_t;
  localparam logic [4:0] OP_HALT = 5'b00001;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] pc, last_pc, redirect_base, redirect_pc;
  logic [31:0]       store [DEPTH];
  logic [31:0]       fetch_word;
  logic              stopped, accept, redirect, halt_op, illegal_op;
  logic              unused_offset_bits;

  assign stopped     = (state == S_IDLE) || (state == S_HALT);
  assign busy        = (state == S_FETCH) || (state == S_ISSUE);
  assign halted      = (state == S_HALT);
  assign instr_valid = (state == S_ISSUE);
  assign accept      = instr_valid & instr_ready;
  assign redirect    = redirect_valid & busy;
  assign halt_op     = (instr_out[31:27] == OP_HALT);

  // A redirect coinciding with acceptance is relative to the instruction just handed over.
  assign redirect_base      = accept ? instr_pc : last_pc;
  assign redirect_pc        = redirect_base + redirect_offset[ADDR_W-1:0];
  assign unused_offset_bits = ^redirect_offset[26:ADDR_W];

`ifdef ISSUE_ILLEGAL_OPCODE_EN
  assign illegal_op = (store[pc][31:27] > 5'b10110);
  assign fetch_word = illegal_op ? 32'h0 : store[pc];
`else
  assign illegal_op = 1'b0;
  assign fetch_word = store[pc];
`endif

  // NOTE: the program store has no reset so it maps onto plain RAM; only control state is reset.
  always_ff @(posedge clk) begin
    if (load_we && stopped) store[load_addr] <= load_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // NOTE: next state defaults to the current state first so no path can infer a latch.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE, S_HALT: if (start) state_nxt = S_FETCH;
      S_FETCH:        state_nxt = redirect ? S_FETCH : S_ISSUE;
      S_ISSUE: begin
        if (redirect)    state_nxt = S_FETCH;
        else if (accept) state_nxt = halt_op ? S_HALT : S_FETCH;
      end
      default:        state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc           <= '0;
      last_pc      <= '0;
      instr_out    <= '0;
      instr_pc     <= '0;
      issued_count <= '0;
`ifdef ISSUE_ILLEGAL_OPCODE_EN
      illegal_seen <= 1'b0;
`endif
    end else begin
      if (stopped && start) begin
        pc           <= '0;
        issued_count <= '0;
`ifdef ISSUE_ILLEGAL_OPCODE_EN
        illegal_seen <= 1'b0;
`endif
      end
      if (accept) begin
        last_pc <= instr_pc;
        if (issued_count != '1) issued_count <= issued_count + CNT_W'(1);
      end
      if (redirect)                pc <= redirect_pc;
      else if (accept && !halt_op) pc <= instr_pc + ADDR_W'(1);
      // A fetch overtaken by a redirect is dropped; the refetch follows next cycle.
      if (state == S_FETCH && !redirect) begin
        instr_out <= fetch_word;
        instr_pc  <= pc;
`ifdef ISSUE_ILLEGAL_OPCODE_EN
        if (illegal_op) illegal_seen <= 1'b1;
`endif
      end
    end
  end

endmodule
